// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester link (encoder and decoder).
// Contents: default oscillator/data-rate values, bit-time derivation helpers,
// a constant clog2 and the encoder FSM state encoding.
package manchester_pkg;

  localparam int unsigned DEF_OSC_FRE   = 32;
  localparam int unsigned DEF_DATA_RATE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } mch_state_e;

  // Osc cycles per line bit.
  function automatic int unsigned bit_time(input int unsigned osc_fre,
                                           input int unsigned data_rate);
    return osc_fre / data_rate;
  endfunction

  // Osc cycles per half-bit.
  function automatic int unsigned half_time(input int unsigned osc_fre,
                                            input int unsigned data_rate);
    return bit_time(osc_fre, data_rate) / 2;
  endfunction

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/manchester_enc_if.sv
// Word handshake between a producer (master) and the Manchester encoder (slave).
// Signals: tx_data  - word to send
//          tx_valid - tx_data valid
//          tx_ready - encoder can accept a word this cycle
interface manchester_enc_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/manchester_bit_timer.sv
// Phase counter for one line bit: counts 0..BIT_TIME-1 while run is high.
// Ports: osc, rst_n - clock and async active-low reset
//        run        - advance the phase counter
//        clr        - synchronous clear to phase 0 (wins over run)
//        mid        - phase == HALF-1 (last cycle of the first half)
//        bit_end    - phase == BIT_TIME-1 (last cycle of the bit)
module manchester_bit_timer
  import manchester_pkg::*;
#(
  parameter int unsigned BIT_TIME = 16,
  parameter int unsigned HALF     = 8
) (
  input  logic osc,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic mid,
  output logic bit_end
);

  localparam int unsigned PW = clog2_u(BIT_TIME);

  logic [PW-1:0] phase;

  // Phase register; wraps to 0 after the last cycle of each bit.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (run) begin
      phase <= bit_end ? '0 : phase + PW'(1);
    end
  end

  assign mid     = (phase == PW'(HALF - 1));
  assign bit_end = (phase == PW'(BIT_TIME - 1));

endmodule

// File: rtl/manchester_enc.sv
// Manchester transmitter: accepts words over a valid/ready handshake and sends
// an alternating preamble followed by the word MSB first (1 = low->high).
// Ports: osc, rst_n       - clock and async active-low reset
//        tx (slave)       - tx_data / tx_valid / tx_ready word handshake
//        manchester_data  - registered line output
//        tx_busy          - high while preamble or data is on the line
//        tx_done          - one-cycle pulse after a frame that is not chained
module manchester_enc
  import manchester_pkg::*;
#(
  parameter int unsigned OSC_FRE   = DEF_OSC_FRE,
  parameter int unsigned DATA_RATE = DEF_DATA_RATE,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PRE_BITS  = 8,
  parameter bit          IDLE_LVL  = 1'b0
) (
  input  logic            osc,
  input  logic            rst_n,
  manchester_enc_if.slave tx,
  output logic            manchester_data,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int unsigned BIT_TIME = bit_time(OSC_FRE, DATA_RATE);
  localparam int unsigned HALF     = half_time(OSC_FRE, DATA_RATE);
  localparam int unsigned CNT_MAX  = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
  localparam int unsigned BW       = clog2_u(CNT_MAX);

  if ((BIT_TIME % 2) != 0 || BIT_TIME < 4) begin : g_bad_bit_time
    $error("manchester_enc: BIT_TIME must be even and >= 4");
  end
  if (PRE_BITS < 2 || PRE_BITS > 255) begin : g_bad_pre_bits
    $error("manchester_enc: PRE_BITS must be in 2..255");
  end

  mch_state_e        state, state_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              line_n, busy_n, done_n;
  logic              mid, bit_end;
  logic              timer_run, timer_clr;
  logic              pre_last, data_last, accept;

  assign timer_run = (state != IDLE);
  assign timer_clr = (state == IDLE);

  manchester_bit_timer #(
    .BIT_TIME (BIT_TIME),
    .HALF     (HALF)
  ) u_timer (
    .osc     (osc),
    .rst_n   (rst_n),
    .run     (timer_run),
    .clr     (timer_clr),
    .mid     (mid),
    .bit_end (bit_end)
  );

  assign pre_last  = (bit_cnt == BW'(PRE_BITS - 1));
  assign data_last = (bit_cnt == BW'(DATA_W - 1));

  assign tx.tx_ready = (state == IDLE) || ((state == DATA) && bit_end && data_last);
  assign accept      = tx.tx_valid && tx.tx_ready;

  // State, counters and line register.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      manchester_data <= IDLE_LVL;
      tx_busy         <= 1'b0;
      tx_done         <= 1'b0;
    end else begin
      state           <= state_n;
      bit_cnt         <= bit_cnt_n;
      shreg           <= shreg_n;
      manchester_data <= line_n;
      tx_busy         <= busy_n;
      tx_done         <= done_n;
    end
  end

  // Next state. The line register looks one cycle ahead: at mid it takes the
  // bit value, at bit_end the complement of the following bit (or idle level).
  // Preamble bit n is ~n[0], so 1,0,1,0,... starting with 1.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    line_n    = manchester_data;
    busy_n    = tx_busy;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = PRE;
          bit_cnt_n = '0;
          shreg_n   = tx.tx_data;
          line_n    = 1'b0;
          busy_n    = 1'b1;
        end
      end
      PRE: begin
        if (mid) begin
          line_n = ~bit_cnt[0];
        end else if (bit_end) begin
          if (pre_last) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            line_n    = ~shreg[DATA_W-1];
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            line_n    = ~bit_cnt[0];
          end
        end
      end
      DATA: begin
        if (mid) begin
          line_n = shreg[DATA_W-1];
        end else if (bit_end) begin
          if (!data_last) begin
            bit_cnt_n = bit_cnt + BW'(1);
            shreg_n   = shreg << 1;
            line_n    = ~shreg_n[DATA_W-1];
          end else if (accept) begin
            bit_cnt_n = '0;
            shreg_n   = tx.tx_data;
            line_n    = ~tx.tx_data[DATA_W-1];
          end else begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            line_n    = IDLE_LVL;
            busy_n    = 1'b0;
            done_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = '0;
        line_n    = IDLE_LVL;
        busy_n    = 1'b0;
      end
    endcase
  end

endmodule
